// File: rtl/event_debouncer.sv
// N-channel debouncer: synchroniser, per-channel settle FSM/timer, press/release pulses.
// Optional long-press hold counters are built when DEBOUNCE_LONG_PRESS_EN is defined.
module event_debouncer #(
  parameter int    WIDTH         = 4,
  parameter string POLARITY      = "LOW",
  parameter int    SYNC_STAGES   = 2,
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter int    LONG_COUNT    = 1000,
  parameter int    LONG_WIDTH    = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press,
  output logic             event_any
);

  // state  | meaning
  // STABLE | sync_n matches data_out, timer idle
  // SETTLE | sync_n differs, timer counting towards commit
  typedef enum logic {STABLE, SETTLE} state_t;

  localparam logic IDLE_PIN = (POLARITY == "LOW") ? 1'b1 : 1'b0;
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 2 || 64'(TIMEOUT) >= (64'd1 << TIMEOUT_WIDTH)) begin : g_bad_timeout
    $error("TIMEOUT must be >= 2 and fit in TIMEOUT_WIDTH bits");
  end
  if (POLARITY != "LOW" && POLARITY != "HIGH") begin : g_bad_pol
    $error("POLARITY must be LOW or HIGH");
  end
  if (LONG_COUNT < 1 || LONG_WIDTH < 1) begin : g_bad_long
    $error("LONG_COUNT and LONG_WIDTH must be positive");
  end

  logic [WIDTH-1:0]         sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]         sync_d [SYNC_STAGES];
  logic [WIDTH-1:0]         sync_n;
  state_t                   state_q [WIDTH];
  state_t                   state_d [WIDTH];
  logic [TIMEOUT_WIDTH-1:0] timer_q [WIDTH];
  logic [TIMEOUT_WIDTH-1:0] timer_d [WIDTH];
  logic [WIDTH-1:0]         level_q, level_d;
  logic [WIDTH-1:0]         press_q, press_d;
  logic [WIDTH-1:0]         release_q, release_d;

  assign sync_n = (POLARITY == "LOW") ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = data_in;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  // A reversion is checked before the terminal count, so it also aborts the commit edge.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        STABLE: begin
          if (sync_n[i] != level_q[i]) begin
            state_d[i] = SETTLE;
            timer_d[i] = '0;
          end
        end
        SETTLE: begin
          if (sync_n[i] == level_q[i]) begin
            state_d[i] = STABLE;
          end else if (timer_q[i] == TIMER_LAST) begin
            state_d[i]   = STABLE;
            level_d[i]   = sync_n[i];
            press_d[i]   = sync_n[i];
            release_d[i] = ~sync_n[i];
          end else begin
            timer_d[i] = timer_q[i] + 1'b1;
          end
        end
        default: state_d[i] = STABLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= {WIDTH{IDLE_PIN}};
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        timer_q[i] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign data_out      = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign event_any     = |(press_q | release_q);

`ifdef DEBOUNCE_LONG_PRESS_EN
  if (64'(LONG_COUNT) * 64'(TIMEOUT) >= (64'd1 << LONG_WIDTH)) begin : g_bad_hold
    $error("LONG_COUNT*TIMEOUT must fit in LONG_WIDTH bits");
  end

  localparam logic [LONG_WIDTH-1:0] HOLD_MAX = LONG_WIDTH'(LONG_COUNT * TIMEOUT);

  logic [LONG_WIDTH-1:0] hold_q [WIDTH];
  logic [LONG_WIDTH-1:0] hold_d [WIDTH];
  logic [WIDTH-1:0]      long_q, long_d;

  // Hold count is cleared on the rising commit so it reads k exactly k cycles later.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!level_d[i] || !level_q[i])  hold_d[i] = '0;
      else if (hold_q[i] == HOLD_MAX)  hold_d[i] = hold_q[i];
      else                             hold_d[i] = hold_q[i] + 1'b1;
      long_d[i] = level_d[i] && (hold_d[i] == HOLD_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= '0;
      long_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= hold_d[i];
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_event_debouncer.sv
// Randomised and directed bench for event_debouncer against a run-length reference model.
module tb_event_debouncer;
  localparam int W     = 4;
  localparam int SS    = 2;
  localparam int TO    = 4;
  localparam int TW    = 4;
  localparam int LC    = 5;
  localparam int LW    = 8;
  localparam int LIMIT = LC * TO;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '1;
  logic [W-1:0] data_out, press_pulse, release_pulse, long_press;
  logic         event_any;

  event_debouncer #(
    .WIDTH(W), .POLARITY("LOW"), .SYNC_STAGES(SS), .TIMEOUT(TO),
    .TIMEOUT_WIDTH(TW), .LONG_COUNT(LC), .LONG_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(rst), .data_in(data_in), .data_out(data_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_press(long_press), .event_any(event_any)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the settle logic reduces to "the delayed asserted level has disagreed with
  // data_out on TIMEOUT+1 consecutive edges"; the synchroniser is a plain delay line.
  logic [W-1:0] m_out, m_press, m_rel, m_long;
  int           m_run  [W];
  int           m_rise [W];
  int           edge_no;
  logic [W-1:0] pipe [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_press = '0; m_rel = '0; m_long = '0;
    edge_no = 0;
    for (int i = 0; i < W; i++) begin
      m_run[i]  = 0;
      m_rise[i] = 0;
    end
    pipe.delete();
    for (int s = 0; s < SS; s++) pipe.push_back('0);
  endtask

  task automatic model_edge(input logic [W-1:0] pin);
    logic [W-1:0] v;
    edge_no++;
    v = pipe.pop_front();
    pipe.push_back(~pin);
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i] !== m_out[i]) begin
        m_run[i]++;
        if (m_run[i] == TO + 1) begin
          m_run[i] = 0;
          m_out[i] = v[i];
          if (v[i]) begin
            m_press[i] = 1'b1;
            m_rise[i]  = edge_no;
          end else begin
            m_rel[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
      m_long[i] = LONG_ON && m_out[i] && ((edge_no - m_rise[i]) >= LIMIT);
    end
  endtask

  task automatic check_outputs();
    check("data_out", data_out, m_out);
    check("press_pulse", press_pulse, m_press);
    check("release_pulse", release_pulse, m_rel);
    check("long_press", long_press, m_long);
    check("event_any", event_any, |(m_press | m_rel));
  endtask

  task automatic step(input logic [W-1:0] pin);
    data_in = pin;
    @(posedge clk);
    model_edge(pin);
    #1;
    check_outputs();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("async_rst_data_out", data_out, 0);
    check("async_rst_press", press_pulse, 0);
    check("async_rst_release", release_pulse, 0);
    check("async_rst_long", long_press, 0);
    check("async_rst_event", event_any, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] pins;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // clean press and release on channel 0
    for (int k = 0; k < 8; k++) begin
      step(4'b1110);
      check("t1_press0", press_pulse[0], k == 6);
      check("t1_others", data_out[3:1], 0);
    end
    repeat (8) step(4'b1111);

    // glitch shorter than the settle window
    repeat (3) step(4'b1101);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111);
      check("t2_level1", data_out[1], 0);
    end

    // reversion landing exactly on the commit edge
    repeat (4) step(4'b1011);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111);
      check("t3_press2", press_pulse[2], 0);
    end

    // simultaneous release on channels 0 and 3
    repeat (8) step(4'b0110);
    check("t4_held", data_out, 4'b1001);
    for (int k = 0; k < 8; k++) begin
      step(4'b1111);
      check("t4_release", release_pulse, (k == 6) ? 4'b1001 : 4'b0000);
      check("t4_event", event_any, k == 6);
    end

    // long press, then release
    repeat (SS + TO + LIMIT + 5) step(4'b1110);
    check("t5_long", long_press[0], LONG_ON);
    repeat (8) step(4'b1111);

    // reset while channel 0 is mid-settle (timer at 2)
    repeat (5) step(4'b1110);
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'b1110);
      check("t6_press0", press_pulse[0], k == 6);
    end
    repeat (8) step(4'b1111);

    // random toggling: a fast phase for glitches, a slow phase for long presses
    pins = '1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, (c < 1500) ? 7 : 60) == 0) pins[i] = ~pins[i];
      if ($urandom_range(0, 499) == 0) pulse_reset();
      step(pins);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
